// File: rtl/cv32e40p_alu_ft_reconfig.sv
// Fault-tolerant EX stage ALU reconfiguration sequencer.
// Collects permanent-fault remove requests into a sticky healthy-ALU mask.
// A switchover is sequenced as: wait for EX idle, stall and drain, then apply
// the new mask. The voter mode and the primary ALU select follow the mask.
module cv32e40p_alu_ft_reconfig #(
    parameter int unsigned NUM_ALU      = 3,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic [NUM_ALU-1:0] alu_remove_i,
    input  logic               ex_busy_i,
    output logic [NUM_ALU-1:0] alu_active_o,
    output logic [1:0]         voter_mode_o,
    output logic [1:0]         alu_sel_o,
    output logic               reconfig_stall_o,
    output logic               reconfig_ack_o,
    output logic               fatal_o
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_PENDING = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_APPLY   = 2'd3
    } state_t;

    // Voter mode from the number of healthy ALUs; the fatal flag forces fail.
    function automatic logic [1:0] mode_f(input logic [NUM_ALU-1:0] m, input logic f);
        logic [2:0] pc;
        logic [1:0] md;
        pc = 3'd0;
        for (int i = 0; i < NUM_ALU; i++) begin
            pc = pc + {2'b00, m[i]};
        end
        case (pc)
            3'd3:    md = 2'b00;
            3'd2:    md = 2'b01;
            3'd1:    md = 2'b10;
            default: md = 2'b11;
        endcase
        if (f) begin
            md = 2'b11;
        end
        return md;
    endfunction

    // Index of the lowest-numbered healthy ALU.
    function automatic logic [1:0] sel_f(input logic [NUM_ALU-1:0] m);
        logic [1:0] s;
        s = 2'd0;
        for (int i = NUM_ALU - 1; i >= 0; i--) begin
            if (m[i]) begin
                s = 2'(i);
            end
        end
        return s;
    endfunction

    state_t             state_r, state_next_s;
    logic [NUM_ALU-1:0] pending_r, pending_next_s;
    logic [NUM_ALU-1:0] snap_r, snap_next_s;
    logic [NUM_ALU-1:0] active_r, active_next_s;
    logic [NUM_ALU-1:0] new_mask_s;
    logic [CNT_W-1:0]   cnt_r, cnt_next_s;
    logic               fatal_r, fatal_next_s;
    logic [1:0]         mode_r;
    logic [1:0]         sel_r;
    logic               stall_r;
    logic               ack_r;

    // Next-state, request capture and mask update logic.
    always_comb begin
        state_next_s  = state_r;
        snap_next_s   = snap_r;
        cnt_next_s    = cnt_r;
        active_next_s = active_r;
        fatal_next_s  = fatal_r;
        new_mask_s    = active_r & ~snap_r;

        // Requests for ALUs already out of service are dropped; the bits
        // being applied this cycle are retired, anything newer stays pending.
        if (state_r == ST_APPLY) begin
            pending_next_s = (pending_r | (alu_remove_i & active_r)) & ~snap_r;
        end else begin
            pending_next_s = pending_r | (alu_remove_i & active_r);
        end

        case (state_r)
            ST_NORMAL: begin
                if (pending_r != {NUM_ALU{1'b0}}) begin
                    state_next_s = ST_PENDING;
                end else begin
                    state_next_s = ST_NORMAL;
                end
            end
            ST_PENDING: begin
                if (!ex_busy_i) begin
                    snap_next_s  = pending_r;
                    cnt_next_s   = CNT_W'(DRAIN_CYCLES - 1);
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_PENDING;
                end
            end
            ST_DRAIN: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = ST_APPLY;
                end else begin
                    cnt_next_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    state_next_s = ST_DRAIN;
                end
            end
            ST_APPLY: begin
                state_next_s = ST_NORMAL;
                // Never take the last healthy ALU out of service.
                if (new_mask_s != {NUM_ALU{1'b0}}) begin
                    active_next_s = new_mask_s;
                end else begin
                    fatal_next_s = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_NORMAL;
            end
        endcase
    end

    // State, mask and registered output update with synchronous reset.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_r   <= ST_NORMAL;
            pending_r <= {NUM_ALU{1'b0}};
            snap_r    <= {NUM_ALU{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            active_r  <= {NUM_ALU{1'b1}};
            fatal_r   <= 1'b0;
            mode_r    <= mode_f({NUM_ALU{1'b1}}, 1'b0);
            sel_r     <= 2'd0;
            stall_r   <= 1'b0;
            ack_r     <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pending_r <= pending_next_s;
            snap_r    <= snap_next_s;
            cnt_r     <= cnt_next_s;
            active_r  <= active_next_s;
            fatal_r   <= fatal_next_s;
            mode_r    <= mode_f(active_next_s, fatal_next_s);
            sel_r     <= sel_f(active_next_s);
            stall_r   <= (state_next_s == ST_DRAIN) || (state_next_s == ST_APPLY);
            ack_r     <= (state_next_s == ST_APPLY);
        end
    end

    assign alu_active_o     = active_r;
    assign voter_mode_o     = mode_r;
    assign alu_sel_o        = sel_r;
    assign reconfig_stall_o = stall_r;
    assign reconfig_ack_o   = ack_r;
    assign fatal_o          = fatal_r;

endmodule
